// File: rtl/nand3_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// nand3_sweep_ctrl_if
// Groups every non-clock signal of the NAND3 sweep controller.
//   master : the sweep controller (drives a/b/c and the result outputs)
//   slave  : the lab top-level / gate side (drives start, abort, dut_y)
// Signals:
//   start, abort     control levels from the lab top-level
//   dut_y            output of the NAND gate under test
//   a, b, c          gate inputs, vector bits 2..0
//   busy, done, pass sweep status
//   err_count        mismatches in the current/last sweep (saturating)
//   fail_vec         first failing {a,b,c}; fail_seen flags that it is valid
//   state_dbg        controller FSM state (IDLE=0, DRIVE=1, DONE=2)
// Macro NAND3_SWEEP_CONT_EN adds cont (continuous sweeping request) and
// sweep_count (completed sweeps, saturating at 255).
// Handshake: start and abort are plain levels sampled every rising edge;
// abort has priority over start, there is no ready/acknowledge path.
// ---------------------------------------------------------------------------
interface nand3_sweep_ctrl_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             abort;
    logic             dut_y;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       fail_vec;
    logic             fail_seen;
    logic [1:0]       state_dbg;
`ifdef NAND3_SWEEP_CONT_EN
    logic             cont;
    logic [7:0]       sweep_count;

    modport master (
        input  start, abort, dut_y, cont,
        output a, b, c, busy, done, pass, err_count, fail_vec, fail_seen,
        output state_dbg, sweep_count
    );
    modport slave (
        output start, abort, dut_y, cont,
        input  a, b, c, busy, done, pass, err_count, fail_vec, fail_seen,
        input  state_dbg, sweep_count
    );
`else
    modport master (
        input  start, abort, dut_y,
        output a, b, c, busy, done, pass, err_count, fail_vec, fail_seen,
        output state_dbg
    );
    modport slave (
        output start, abort, dut_y,
        input  a, b, c, busy, done, pass, err_count, fail_vec, fail_seen,
        input  state_dbg
    );
`endif
endinterface

// File: rtl/nand3_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nand3_sweep_ctrl
// Exhaustively exercises a three-input NAND gate: drives the 8 vectors
// {a,b,c} = 000..111 in counting order, holds each for HOLD_CYCLES clocks,
// samples dut_y in the last cycle of each hold and compares it with
// ~(a&b&c). Reports a saturating error count, the first failing vector and
// done/pass status.
// Parameters:
//   HOLD_CYCLES  clocks each vector is driven, sample cycle included (>=1)
//   ERR_W        width of err_count
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          nand3_sweep_ctrl_if.master (start/abort/dut_y in,
//                a/b/c, status and results out, state_dbg)
// Optional macro NAND3_SWEEP_CONT_EN: with cont=1 at the end of the last
// vector the sweep restarts at 000 instead of finishing; results accumulate
// and sweep_count counts completed sweeps.
// All outputs are registered.
// ---------------------------------------------------------------------------
module nand3_sweep_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 4
) (
    input logic                clk,
    input logic                rst,
    nand3_sweep_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // HOLD_CYCLES=1 would give a zero-width counter; keep one bit that stays 0.
    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [2:0]       abc_q, abc_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       fvec_q, fvec_d;
    logic             fseen_q, fseen_d;
`ifdef NAND3_SWEEP_CONT_EN
    logic [7:0]       swp_q, swp_d;
`endif

    logic sample;
    logic mismatch;
    logic last_sweep;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            abc_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
            fseen_q <= 1'b0;
`ifdef NAND3_SWEEP_CONT_EN
            swp_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            abc_q   <= abc_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fseen_q <= fseen_d;
`ifdef NAND3_SWEEP_CONT_EN
            swp_q   <= swp_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        abc_d      = abc_q;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fvec_d     = fvec_q;
        fseen_d    = fseen_q;
`ifdef NAND3_SWEEP_CONT_EN
        swp_d      = swp_q;
        last_sweep = ~bus.cont;
`else
        last_sweep = 1'b1;
`endif
        sample     = 1'b0;
        mismatch   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.abort) begin
                    // Results from the last sweep stay visible after an abort.
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (bus.start) begin
                    state_d = S_DRIVE;
                    vec_d   = '0;
                    abc_d   = '0;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fvec_d  = '0;
                    fseen_d = 1'b0;
`ifdef NAND3_SWEEP_CONT_EN
                    swp_d   = '0;
`endif
                end
            end

            S_DRIVE: begin
                if (bus.abort) begin
                    // Partial results are kept; a sample due this cycle is dropped.
                    state_d = S_IDLE;
                    vec_d   = '0;
                    abc_d   = '0;
                    hold_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    hold_d = hold_q + HW'(1);
                    sample = (hold_q == HOLD_LAST);
                    if (sample) begin
                        // abc_q equals vec_q while driving, so this is the gate's
                        // response to the vector currently applied.
                        mismatch = (bus.dut_y != ~(&abc_q));
                        if (mismatch) begin
                            if (err_q != ERR_MAX) begin
                                err_d = err_q + ERR_W'(1);
                            end
                            if (!fseen_q) begin
                                fvec_d  = vec_q;
                                fseen_d = 1'b1;
                            end
                        end
                        hold_d = '0;
                        if (vec_q != 3'd7) begin
                            vec_d = vec_q + 3'd1;
                            abc_d = vec_q + 3'd1;
                        end else begin
                            vec_d = '0;
                            abc_d = '0;
`ifdef NAND3_SWEEP_CONT_EN
                            if (swp_q != 8'hFF) begin
                                swp_d = swp_q + 8'd1;
                            end
`endif
                            if (last_sweep) begin
                                // pass includes the mismatch sampled this cycle.
                                state_d = S_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                pass_d  = (err_d == '0);
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.a         = abc_q[2];
    assign bus.b         = abc_q[1];
    assign bus.c         = abc_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fvec_q;
    assign bus.fail_seen = fseen_q;
    assign bus.state_dbg = state_q;
`ifdef NAND3_SWEEP_CONT_EN
    assign bus.sweep_count = swp_q;
`endif

endmodule

// File: tb/tb_nand3_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nand3_sweep_ctrl
// Two controllers share clock and reset: dut1 (HOLD_CYCLES=4, ERR_W=4) and
// dut2 (HOLD_CYCLES=1, ERR_W=2, shows err_count saturation). Each gate model
// is an ideal NAND whose output is inverted for the vectors set in a fault
// mask, so the expected sweep result follows directly from the mask:
// error count = faulty vectors (saturated), first fail = lowest faulty vector.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_nand3_sweep_ctrl;
    localparam int H1 = 4;
    localparam int E1 = 4;
    localparam int H2 = 1;
    localparam int E2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mask1 = 8'h00;
    logic [7:0] mask2 = 8'h00;
    logic [2:0] exp_q[$];
    int busy1_cyc = 0;
    int busy2_cyc = 0;

    always #5 clk = ~clk;

    nand3_sweep_ctrl_if #(.ERR_W(E1)) if1();
    nand3_sweep_ctrl_if #(.ERR_W(E2)) if2();

    nand3_sweep_ctrl #(.HOLD_CYCLES(H1), .ERR_W(E1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    nand3_sweep_ctrl #(.HOLD_CYCLES(H2), .ERR_W(E2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // Gate models: ideal NAND, inverted on the vectors flagged in the mask.
    assign if1.dut_y = ~(if1.a & if1.b & if1.c) ^ mask1[{if1.a, if1.b, if1.c}];
    assign if2.dut_y = ~(if2.a & if2.b & if2.c) ^ mask2[{if2.a, if2.b, if2.c}];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int n_err(input logic [7:0] m, input int sweeps, input int w);
        int e;
        int mx;
        e  = $countones(m) * sweeps;
        mx = (1 << w) - 1;
        return (e > mx) ? mx : e;
    endfunction

    function automatic int first_fail(input logic [7:0] m);
        int r;
        r = 0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    // Scoreboard for the vector sequence of dut1: one entry per busy cycle.
    always @(negedge clk) begin
        logic [2:0] e;
        if (if1.busy) begin
            busy1_cyc++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
            check("abc_trace", 32'({if1.a, if1.b, if1.c}), 32'(e));
        end
        if (if2.busy) busy2_cyc++;
    end

    task automatic push_trace(input int sweeps);
        exp_q.delete();
        for (int s = 0; s < sweeps; s++)
            for (int v = 0; v < 8; v++)
                for (int k = 0; k < H1; k++)
                    exp_q.push_back(3'(v));
    endtask

    task automatic check_reset_vals(input string t);
        check({t, "_busy"}, 32'(if1.busy), 0);
        check({t, "_done"}, 32'(if1.done), 0);
        check({t, "_pass"}, 32'(if1.pass), 0);
        check({t, "_abc"}, 32'({if1.a, if1.b, if1.c}), 0);
        check({t, "_err"}, 32'(if1.err_count), 0);
        check({t, "_fvec"}, 32'(if1.fail_vec), 0);
        check({t, "_fseen"}, 32'(if1.fail_seen), 0);
`ifdef NAND3_SWEEP_CONT_EN
        check({t, "_swp"}, 32'(if1.sweep_count), 0);
`endif
    endtask

    task automatic wait_vec(input logic [2:0] v);
        for (int i = 0; i < 100 && {if1.a, if1.b, if1.c} != v; i++) @(negedge clk);
        check("reach_vec", 32'({if1.a, if1.b, if1.c}), 32'(v));
    endtask

    // Full sweep(s) on dut1 with dut2 started alongside; called on a falling edge.
    task automatic run_sweep(input logic [7:0] m1, input logic [7:0] m2, input int n);
        int edges;
        mask1 = m1;
        mask2 = m2;
        push_trace(n);
        busy1_cyc = 0;
        busy2_cyc = 0;
`ifdef NAND3_SWEEP_CONT_EN
        if1.cont = (n > 1);
`endif
        if1.start = 1'b1;
        if2.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        if2.start = 1'b0;
        edges = 1;  // the edge that sampled start is counted as the first
        check("busy_rise", 32'(if1.busy), 1);
        check("done_drop", 32'(if1.done), 0);
        while (!if1.done && edges < 8 * H1 * n + 20) begin
`ifdef NAND3_SWEEP_CONT_EN
            if (n > 1 && if1.sweep_count == 8'(n - 1)) if1.cont = 1'b0;
`endif
            @(negedge clk);
            edges++;
        end
        #1;
        check("done_edges", 32'(edges), 32'(8 * H1 * n + 1));
        check("busy_cycles", 32'(busy1_cyc), 32'(8 * H1 * n));
        check("trace_left", 32'(exp_q.size()), 0);
        check("done1", 32'(if1.done), 1);
        check("busy1", 32'(if1.busy), 0);
        check("abc_idle", 32'({if1.a, if1.b, if1.c}), 0);
        check("pass1", 32'(if1.pass), 32'(m1 == 8'h00));
        check("err1", 32'(if1.err_count), 32'(n_err(m1, n, E1)));
        check("fvec1", 32'(if1.fail_vec), 32'(first_fail(m1)));
        check("fseen1", 32'(if1.fail_seen), 32'(m1 != 8'h00));
`ifdef NAND3_SWEEP_CONT_EN
        check("sweep_count", 32'(if1.sweep_count), 32'(n));
        if1.cont = 1'b0;
`endif
        check("busy2_cycles", 32'(busy2_cyc), 32'(8 * H2));
        check("done2", 32'(if2.done), 1);
        check("pass2", 32'(if2.pass), 32'(m2 == 8'h00));
        check("err2", 32'(if2.err_count), 32'(n_err(m2, 1, E2)));
        check("fvec2", 32'(if2.fail_vec), 32'(first_fail(m2)));
        check("fseen2", 32'(if2.fail_seen), 32'(m2 != 8'h00));
    endtask

    task automatic abort_test(input logic [7:0] m);
        logic [7:0] part;
        part  = m & 8'h07;  // only vectors 0..2 are sampled before the abort
        mask1 = m;
        push_trace(1);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_vec(3'b011);
        if1.abort = 1'b1;
        @(negedge clk);
        if1.abort = 1'b0;
        exp_q.delete();
        check("abort_busy", 32'(if1.busy), 0);
        check("abort_done", 32'(if1.done), 0);
        check("abort_pass", 32'(if1.pass), 0);
        check("abort_abc", 32'({if1.a, if1.b, if1.c}), 0);
        check("abort_err", 32'(if1.err_count), 32'(n_err(part, 1, E1)));
        check("abort_fvec", 32'(if1.fail_vec), 32'(first_fail(part)));
        check("abort_fseen", 32'(if1.fail_seen), 32'(part != 8'h00));
        // start together with abort in IDLE must not begin a sweep
        if1.start = 1'b1;
        if1.abort = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        if1.abort = 1'b0;
        check("startabort_busy", 32'(if1.busy), 0);
        check("startabort_err", 32'(if1.err_count), 32'(n_err(part, 1, E1)));
        @(negedge clk);
        check("startabort_busy2", 32'(if1.busy), 0);
    endtask

    task automatic reset_test();
        mask1 = 8'hFF;  // every vector fails, so results are non-zero before reset
        push_trace(1);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_vec(3'b101);
        check("pre_rst_err", 32'(if1.err_count), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_reset_vals("midrst");
    endtask

    initial begin
        if1.start = 1'b0;
        if1.abort = 1'b0;
        if2.start = 1'b0;
        if2.abort = 1'b0;
`ifdef NAND3_SWEEP_CONT_EN
        if1.cont = 1'b0;
        if2.cont = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        run_sweep(8'h00, 8'h00, 1);   // ideal gate
        run_sweep(8'h80, 8'h80, 1);   // dut_y stuck at 1: only 111 fails
        run_sweep(8'h7F, 8'h7F, 1);   // dut_y stuck at 0: 000..110 fail
        for (int i = 0; i < 6; i++) begin
            run_sweep(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
        end
        abort_test(8'($urandom_range(0, 255)));
        reset_test();
        run_sweep(8'h00, 8'h00, 1);
`ifdef NAND3_SWEEP_CONT_EN
        run_sweep(8'h00, 8'h00, 3);
        run_sweep(8'($urandom_range(1, 255)), 8'h00, 3);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
